div_radix2: RTL and testbench
=============================

Name: div_radix2

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU in the Execute stage.
- Receives operands and start from the ALU. Returns {remainder, quotient} for the 64-bit HI/LO result, which the ALU forwards to the Memory-stage hilo write.
- Drives the ALU's divide-stall request, which the hazard unit turns into stallF/D/E.
- annul_i lets an exception flush in Memory abort a division in flight.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; held high by the ALU while the DIV is stalled in Execute
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- annul_i  in  1  abort the current operation (exception flush)
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  out  1  result valid
- busy_o  out  1  division in progress
- stall_o  out  1  start_i & ~ready_o (combinational)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. Applies in any state, including mid-operation.
- States:
  - IDLE, DIVZERO, ON, END.
  - ready_o = (state==END).
  - busy_o = (state==ON or DIVZERO).
- IDLE:
  - start_i=1 at edge n: latch |opdata1|, |opdata2| (absolute value only when signed_div_i=1), the operand signs and signed_div_i.
  - Next state is DIVZERO if opdata2_i==0, else ON with counter=0.
  - Operand inputs are ignored outside this sampling edge.
- ON:
  - One restoring step per edge: shift {rem, quot} left by 1; trial = rem - divisor; if trial is non-negative, rem = trial and quot LSB = 1.
  - Steps occur at edges n+1..n+32. counter wraps 31->0 at the final step.
  - At edge n+32, the state moves to END and result_o is written with the sign fixup below.
  - ready_o is therefore high in the cycle after edge n+32 (latency 32 cycles).
- Sign fixup (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Widths: 32-bit two's complement, no overflow trap. 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- DIVZERO:
  - At edge n+1, go to END with result_o = {opdata1 as latched (original signed value), 32'hFFFFFFFF}.
  - ready_o is high after edge n+1.
- END:
  - While start_i=1, stay in END and hold ready_o=1 and result_o.
  - start_i=0 moves to IDLE; ready_o falls.
  - result_o holds its value until the next END entry or reset.
- annul_i:
  - annul_i=1 in ON or DIVZERO: go to IDLE at the next edge. result_o is unchanged and ready_o never asserts.
  - annul_i=1 in END also goes to IDLE.
  - In IDLE, annul_i takes priority over start_i: no operation starts.
- Simultaneous rst and annul_i: rst wins.
- A start_i that stays high after annul_i causes a new start from IDLE.

Decomposition:
- Shared defines: add state encodings (DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END) and the DIV_WIDTH constant alongside the existing ALUOP definitions.
- One combinational sub-module, div_step:
  - Inputs: {rem, quot}, divisor.
  - Output: next {rem, quot}.
  - Keeps the iteration datapath separately testable.

Test Plan:
- Unsigned 100/7, start at edge n: busy_o=1 over n+1..n+32; ready_o=1 after n+32; result_o={32'd2, 32'd14}; stall_o=0 once ready.
- Signed -7/2 (0xFFFFFFF9 / 2): q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2: q=0xFFFFFFFD, r=1.
- Divide by zero, unsigned 0x1234/0: ready_o after edge n+1; result_o={0x00001234, 0xFFFFFFFF}. Signed 0x80000000 / 0xFFFFFFFF: {0, 0x80000000}.
- Handshake: hold start_i=1 for 5 cycles in END, so ready_o and result_o are stable. Drop start_i: ready_o=0 next cycle. A new DIVU 9/3 then gives {0, 3}.
- annul_i pulse at edge n+10: state IDLE and busy_o=0 next cycle; ready_o never asserts; result_o keeps the previous value.
- rst asserted at edge n+15 mid-operation: all outputs 0 next cycle. A start 2 cycles after reset deasserts gives a correct result (50/5 gives {0, 10}).

Source files
------------

// File: rtl/div_radix2_pkg.sv
// Shared divider definitions: FSM state encodings and the default operand width.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration on the packed {remainder, quotient} register.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_remquot,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_remquot
);

    logic [2*WIDTH-1:0] w_shifted;
    logic [WIDTH:0]     w_trial;

    // The bit shifted out of the remainder is kept as the trial MSB so that
    // divisors with the top bit set still compare correctly.
    always_comb begin
        w_shifted = {i_remquot[2*WIDTH-2:0], 1'b0};
        w_trial   = {i_remquot[2*WIDTH-1], w_shifted[2*WIDTH-1:WIDTH]} - {1'b0, i_divisor};
        o_remquot = w_shifted;
        if (!w_trial[WIDTH]) begin
            o_remquot = {w_trial[WIDTH-1:0], w_shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU with abort and stall request.
//
// state       | meaning
// DIV_IDLE    | waiting for start_i; operands sampled on the start edge
// DIV_DIVZERO | divisor was zero; canned result written on the next edge
// DIV_ON      | one restoring step per cycle, WIDTH cycles
// DIV_END     | result valid, held while start_i stays high
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stall_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_remquot;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;

    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_load;
    logic               w_last;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] a, input logic sgn);
        return (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    endfunction

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .i_remquot (r_remquot),
        .i_divisor (r_divisor),
        .o_remquot (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (!annul_i && start_i) begin
                    w_state_nxt = (opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
                end
            end
            DIV_DIVZERO: w_state_nxt = annul_i ? DIV_IDLE : DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt = DIV_IDLE;
                end else if (r_cnt == LAST_STEP) begin
                    w_state_nxt = DIV_END;
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    assign w_load     = (r_state == DIV_IDLE) && start_i && !annul_i;
    assign w_last     = (r_state == DIV_ON) && !annul_i && (r_cnt == LAST_STEP);
    assign w_quot_fix = r_neg_q ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? (~w_step[2*WIDTH-1:WIDTH] + 1'b1) : w_step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_remquot  <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
        end else begin
            if (w_load) begin
                r_cnt      <= '0;
                r_remquot  <= {{WIDTH{1'b0}}, abs_val(opdata1_i, signed_div_i)};
                r_divisor  <= abs_val(opdata2_i, signed_div_i);
                r_dividend <= opdata1_i;
                r_neg_q    <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                r_neg_r    <= signed_div_i && opdata1_i[WIDTH-1];
            end else if (r_state == DIV_ON && !annul_i) begin
                r_cnt     <= r_cnt + 1'b1;
                r_remquot <= w_step;
            end

            // Result register changes only on entry to END; annul leaves it alone.
            if (w_last) begin
                r_result <= {w_rem_fix, w_quot_fix};
            end else if (r_state == DIV_DIVZERO && !annul_i) begin
                r_result <= {r_dividend, {WIDTH{1'b1}}};
            end
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == DIV_END);
    assign busy_o   = (r_state == DIV_ON) || (r_state == DIV_DIVZERO);
    assign stall_o  = start_i && !ready_o;

endmodule

// File: tb/tb_div_radix2.sv
// Directed self-checking bench for div_radix2 with hand-computed results.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .stall_o      (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start at edge n, wait (bounded) for ready, check latency/result/handshake.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0;
        lat = 0;
        check({tag, "_busy_first"}, {63'd0, busy_o}, 64'd1);
        while (!ready_o && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_stall_ready"}, {62'd0, stall_o, busy_o}, 64'd0);
        start_i = 1'b0;
        tick();
        check({tag, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        annul_i      = 1'b0;
        tick();
        tick();
        check("reset_outputs", {result_o[62:0], ready_o}, 64'd0);
        check("reset_flags", {61'd0, busy_o, stall_o, result_o[63]}, 64'd0);
        rst = 1'b0;
        tick();

        // 100/7 unsigned with per-cycle busy/ready tracking and END hold
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("divu100_busy_window", {62'd0, busy_o, ready_o}, 64'd2);
            tick();
        end
        check("divu100_ready", {62'd0, busy_o, ready_o}, 64'd1);
        check("divu100_result", result_o, {32'd2, 32'd14});
        check("divu100_stall", {63'd0, stall_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("divu100_hold", {ready_o, result_o[62:0]}, {1'b1, 31'd2, 32'd14});
        end
        start_i = 1'b0;
        tick();
        check("divu100_drop", {63'd0, ready_o}, 64'd0);
        check("divu100_result_kept", result_o, {32'd2, 32'd14});

        run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("div_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32, {32'd1,         32'hFFFF_FFFD});
        run_div("divu_zero",  1'b0, 32'h0000_1234, 32'd0,         1,  {32'h0000_1234, 32'hFFFF_FFFF});
        run_div("div_zero_s", 1'b1, 32'hFFFF_FFF0, 32'd0,         1,  {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, {32'd0,         32'h8000_0000});
        run_div("divu_big",   1'b0, 32'hFFFF_FFFF, 32'h10,        32, {32'hF,         32'h0FFF_FFFF});
        run_div("divu_msb",   1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32, {32'h7FFF_FFFE, 32'd1});
        run_div("divu_9_3",   1'b0, 32'd9,         32'd3,         32, {32'd0,         32'd3});

        // annul at edge n+10
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_idle", {62'd0, busy_o, ready_o}, 64'd0);
        check("annul_result_kept", result_o, {32'd0, 32'd3});
        for (int i = 0; i < 35; i++) begin
            tick();
            check("annul_no_ready", {62'd0, busy_o, ready_o}, 64'd0);
        end

        // annul in IDLE blocks start; a held start restarts afterwards
        opdata1_i = 32'd21;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        tick();
        check("annul_idle_prio", {63'd0, busy_o}, 64'd0);
        annul_i = 1'b0;
        run_div("restart_21_4", 1'b0, 32'd21, 32'd4, 32, {32'd1, 32'd5});

        // synchronous reset at edge n+15
        opdata1_i = 32'd77;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        check("rst_mid_outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
        check("rst_mid_result_hi", {62'd0, result_o[63:62]}, 64'd0);
        rst = 1'b0;
        tick();
        tick();
        run_div("after_rst_50_5", 1'b0, 32'd50, 32'd5, 32, {32'd0, 32'd10});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
